refresh_scheduler: RTL and testbench



---
 rtl/refresh_scheduler_pkg.sv | 14 +
 rtl/refresh_scheduler_refi_timer.sv | 24 ++
 rtl/refresh_scheduler.sv | 83 ++++++++
 tb/tb_refresh_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/refresh_scheduler_pkg.sv
// Shared constants and FSM encoding for the auto-refresh scheduler.
package refresh_scheduler_pkg;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_REQ  = 2'd1,
    RS_GAP  = 2'd2
  } rs_state_e;

  localparam int DEF_TRP          = 5;
  localparam int DEF_TREFI        = 7800;
  localparam int DEF_MAX_POSTPONE = 8;

endpackage

// File: rtl/refresh_scheduler_refi_timer.sv
// tREFI interval down-counter: one-cycle tick at zero, reloads trefi-1.
module refi_timer #(
  parameter int TREFI_W = 28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ref_en,
  input  logic [TREFI_W-1:0] trefi,
  output logic               tick
);

  logic [TREFI_W-1:0] cnt;
  logic               run;

  assign run  = ref_en && (trefi != '0);
  assign tick = run && (cnt == '0);

  // Reload samples trefi live, so a new interval lands at the next reload.
  always_ff @(posedge clk) begin
    if (rst || !run || tick) cnt <= trefi - TREFI_W'(1);
    else                     cnt <= cnt - TREFI_W'(1);
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Periodic auto-refresh request generator with postponement and req/ack handshake.
module refresh_scheduler
  import refresh_scheduler_pkg::*;
#(
  parameter int TREFI_W      = 28,
  parameter int MAX_POSTPONE = DEF_MAX_POSTPONE,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ref_en,
  input  logic [TREFI_W-1:0] trefi,
  input  logic               dispatcher_busy,
  output logic               autoref_req,
  input  logic               autoref_ack,
  output logic [CNT_W-1:0]   pending_cnt,
  output logic               ref_urgent,
  output logic               ref_overflow,
  input  logic               ovf_clr,
  output logic [31:0]        ref_done_cnt
);

  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_POSTPONE);

  rs_state_e state_q, state_d;
  logic      tick, ack_acc, at_max, ovf_set, req_d;

  refi_timer #(.TREFI_W(TREFI_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .ref_en (ref_en),
    .trefi  (trefi),
    .tick   (tick)
  );

  assign ack_acc    = (state_q == RS_REQ) && autoref_ack;
  assign at_max     = (pending_cnt == MAX_P);
  assign ovf_set    = tick && !ack_acc && at_max;
  assign ref_urgent = (pending_cnt >= MAX_P);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RS_IDLE;
      autoref_req <= 1'b0;
    end else begin
      state_q     <= state_d;
      autoref_req <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RS_IDLE: if ((pending_cnt != '0) && (!dispatcher_busy || ref_urgent)) state_d = RS_REQ;
      RS_REQ:  if (autoref_ack) state_d = RS_GAP;
      RS_GAP:  state_d = RS_IDLE;
      default: state_d = RS_IDLE;
    endcase
  end

  // Request is a flop copy of the next state so it rises on the edge entering REQ.
  always_comb begin
    req_d = (state_d == RS_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_cnt  <= '0;
      ref_overflow <= 1'b0;
      ref_done_cnt <= '0;
    end else begin
      if (tick && !ack_acc) begin
        if (!at_max) pending_cnt <= pending_cnt + CNT_W'(1);
      end else if (ack_acc && !tick) begin
        pending_cnt <= pending_cnt - CNT_W'(1);
      end
      if (ovf_set)      ref_overflow <= 1'b1;
      else if (ovf_clr) ref_overflow <= 1'b0;
      if (ack_acc) ref_done_cnt <= ref_done_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler: vector table plus multi-cycle sequences.
module tb_refresh_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ref_en = 1'b1;
  logic [27:0] trefi = 28'd3;
  logic        dispatcher_busy = 1'b0;
  logic        autoref_req;
  logic        autoref_ack = 1'b0;
  logic [3:0]  pending_cnt;
  logic        ref_urgent;
  logic        ref_overflow;
  logic        ovf_clr = 1'b0;
  logic [31:0] ref_done_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  refresh_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .ref_en          (ref_en),
    .trefi           (trefi),
    .dispatcher_busy (dispatcher_busy),
    .autoref_req     (autoref_req),
    .autoref_ack     (autoref_ack),
    .pending_cnt     (pending_cnt),
    .ref_urgent      (ref_urgent),
    .ref_overflow    (ref_overflow),
    .ovf_clr         (ovf_clr),
    .ref_done_cnt    (ref_done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        ack;
    logic        req;
    logic [3:0]  pend;
    logic [31:0] done;
  } vec_t;

  vec_t vt[18];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_req(input int limit, output int n, output bit ok);
    n = 0;
    while (!autoref_req && n < limit) begin
      step();
      n++;
    end
    ok = autoref_req;
  endtask

  task automatic ack_once();
    autoref_ack = 1'b1;
    step();
    autoref_ack = 1'b0;
  endtask

  initial begin
    int  n;
    bit  ok;

    // trefi=3, ref_en=1: ticks land on edges 3,6,9,...
    vt[0]  = '{0, 0, 0, 4'd0, 32'd0};
    vt[1]  = '{0, 0, 0, 4'd0, 32'd0};
    vt[2]  = '{0, 0, 0, 4'd1, 32'd0};
    vt[3]  = '{0, 0, 1, 4'd1, 32'd0};
    vt[4]  = '{0, 0, 1, 4'd1, 32'd0};
    vt[5]  = '{0, 1, 0, 4'd1, 32'd1};
    vt[6]  = '{0, 0, 0, 4'd1, 32'd1};
    vt[7]  = '{0, 0, 1, 4'd1, 32'd1};
    vt[8]  = '{0, 0, 1, 4'd2, 32'd1};
    vt[9]  = '{0, 1, 0, 4'd1, 32'd2};
    vt[10] = '{0, 0, 0, 4'd1, 32'd2};
    vt[11] = '{0, 0, 1, 4'd2, 32'd2};
    vt[12] = '{0, 1, 0, 4'd1, 32'd3};
    vt[13] = '{0, 0, 0, 4'd1, 32'd3};
    vt[14] = '{1, 0, 0, 4'd2, 32'd3};
    vt[15] = '{1, 1, 0, 4'd2, 32'd3};
    vt[16] = '{0, 0, 1, 4'd2, 32'd3};
    vt[17] = '{0, 1, 0, 4'd2, 32'd4};

    trefi = 28'd3; ref_en = 1'b1; dispatcher_busy = 1'b1;
    do_reset();
    chk("rst_req", autoref_req, 0);
    chk("rst_pend", pending_cnt, 0);
    chk("rst_urgent", ref_urgent, 0);
    chk("rst_ovf", ref_overflow, 0);
    chk("rst_done", ref_done_cnt, 0);

    dispatcher_busy = 1'b0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      dispatcher_busy = vt[i].busy;
      autoref_ack     = vt[i].ack;
      step();
      chk($sformatf("vec%0d_req", i), autoref_req, vt[i].req);
      chk($sformatf("vec%0d_pend", i), pending_cnt, vt[i].pend);
      chk($sformatf("vec%0d_done", i), ref_done_cnt, vt[i].done);
    end
    autoref_ack = 1'b0; dispatcher_busy = 1'b0;

    // trefi=1 ticks every cycle
    trefi = 28'd1; dispatcher_busy = 1'b1;
    do_reset();
    repeat (3) step();
    chk("trefi1_pend", pending_cnt, 3);

    // Periodic: req rises at 101, 201, 301
    trefi = 28'd100; dispatcher_busy = 1'b0;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      wait_req(150, n, ok);
      chk($sformatf("per%0d_req_seen", r), ok, 1);
      chk($sformatf("per%0d_rise_cyc", r), cyc, 101 + 100 * r);
      repeat (4) step();
      ack_once();
    end
    chk("per_done", ref_done_cnt, 3);
    chk("per_pend", pending_cnt, 0);

    // Postpone while busy, then urgent override
    trefi = 28'd10; dispatcher_busy = 1'b1;
    do_reset();
    repeat (75) step();
    chk("pp75_pend", pending_cnt, 7);
    chk("pp75_req", autoref_req, 0);
    chk("pp75_urgent", ref_urgent, 0);
    repeat (5) step();
    chk("pp80_pend", pending_cnt, 8);
    chk("pp80_urgent", ref_urgent, 1);
    chk("pp80_req", autoref_req, 0);
    step();
    chk("pp81_req_busy", autoref_req, 1);
    dispatcher_busy = 1'b0; ref_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        wait_req(10, n, ok);
        chk($sformatf("pp_drain%0d_seen", i), ok, 1);
        chk($sformatf("pp_drain%0d_gap", i), n, 2);
      end
      ack_once();
      chk($sformatf("pp_drain%0d_pend", i), pending_cnt, 7 - i);
    end
    chk("pp_done", ref_done_cnt, 8);
    ref_en = 1'b1;

    // Overflow at saturation, clear, tick+ack at max, set-wins
    trefi = 28'd4; dispatcher_busy = 1'b1;
    do_reset();
    repeat (60) step();
    chk("ovf_pend", pending_cnt, 8);
    chk("ovf_flag", ref_overflow, 1);
    chk("ovf_req", autoref_req, 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr", ref_overflow, 0);
    repeat (2) step();
    ack_once();
    chk("ovf_tickack_pend", pending_cnt, 8);
    chk("ovf_tickack_flag", ref_overflow, 0);
    chk("ovf_tickack_done", ref_done_cnt, 1);
    repeat (3) step();
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_set_wins", ref_overflow, 1);

    // Disabled / zero interval: no ticks, pre-loaded pending still drains
    trefi = 28'd3; dispatcher_busy = 1'b1; ref_en = 1'b1;
    do_reset();
    repeat (6) step();
    chk("dis_preload", pending_cnt, 2);
    ref_en = 1'b0;
    repeat (500) step();
    chk("dis_en0_pend", pending_cnt, 2);
    chk("dis_en0_req", autoref_req, 0);
    ref_en = 1'b1; trefi = 28'd0;
    repeat (500) step();
    chk("dis_t0_pend", pending_cnt, 2);
    dispatcher_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_req(10, n, ok);
      chk($sformatf("dis_req%0d", i), ok, 1);
      ack_once();
    end
    repeat (20) step();
    chk("dis_pend_end", pending_cnt, 0);
    chk("dis_req_end", autoref_req, 0);
    chk("dis_done", ref_done_cnt, 2);

    // Reset mid-REQ, then a stray ack
    trefi = 28'd3; dispatcher_busy = 1'b0;
    do_reset();
    wait_req(10, n, ok);
    chk("rmid_req_seen", ok, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rmid_req", autoref_req, 0);
    chk("rmid_pend", pending_cnt, 0);
    ack_once();
    chk("rmid_stray_pend", pending_cnt, 0);
    chk("rmid_stray_done", ref_done_cnt, 0);
    chk("rmid_stray_req", autoref_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
